// File: rtl/quad_gate_bist_pkg.sv
// Shared definitions for the quad 2-input gate BIST: function codes,
// vector count, FSM state encodings and the gate evaluation helper.
package quad_gate_bist_pkg;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_NAND = 3'b010;
    localparam logic [2:0] F_NOR  = 3'b011;
    localparam logic [2:0] F_XOR  = 3'b100;
    localparam logic [2:0] F_XNOR = 3'b101;

    localparam int NUM_VECTORS = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FLAG = 2'd2;

    function automatic logic func_legal(input logic [2:0] func);
        return func <= F_XNOR;
    endfunction

    function automatic logic gate_eval(input logic [2:0] func, input logic a, input logic b);
        logic y;
        case (func)
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_NAND:  y = ~(a & b);
            F_NOR:   y = ~(a | b);
            F_XOR:   y = a ^ b;
            F_XNOR:  y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/quad_gate_vector_rom.sv
// Combinational test-vector table: vector index and gate function in,
// A/B drive pattern and expected Y out, for every gate in parallel.
module quad_gate_vector_rom
    import quad_gate_bist_pkg::*;
#(
    parameter int N_GATES = 4
) (
    input  logic [2:0]         idx,
    input  logic [2:0]         func,
    output logic [N_GATES-1:0] a,
    output logic [N_GATES-1:0] b,
    output logic [N_GATES-1:0] y_exp
);

    always_comb begin
        a = '0;
        b = '0;
        case (idx)
            3'd1: b = '1;
            3'd2: a = '1;
            3'd3: begin
                a = '1;
                b = '1;
            end
            // v4/v5 alternate adjacent gates so a bridge between neighbours shows up
            3'd4: for (int unsigned i = 0; i < N_GATES; i++) a[i] = i[0];
            3'd5: for (int unsigned i = 0; i < N_GATES; i++) b[i] = ~i[0];
            default: ;
        endcase

        y_exp = '0;
        for (int unsigned i = 0; i < N_GATES; i++) begin
            y_exp[i] = gate_eval(func, a[i], b[i]);
        end
    end

endmodule

// File: rtl/quad_gate_bist.sv
// BIST sequencer for one quad 2-input gate package: drives six vectors,
// waits SETTLE cycles per vector, samples Y and accumulates a fail mask.
module quad_gate_bist
    import quad_gate_bist_pkg::*;
#(
    parameter int N_GATES = 4,
    parameter int SETTLE  = 2
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               START,
    input  logic [2:0]         FUNC,
    output logic [N_GATES-1:0] A,
    output logic [N_GATES-1:0] B,
    input  logic [N_GATES-1:0] Y,
    output logic               BUSY,
    output logic               DONE,
    output logic               PASS,
    output logic [N_GATES-1:0] FAIL_MASK,
    output logic               ERR
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2:0]         idx;
    logic [2:0]         func_q;
    logic [N_GATES-1:0] exp_q;

    logic [2:0]         load_idx;
    logic [2:0]         rom_func;
    logic [N_GATES-1:0] rom_a;
    logic [N_GATES-1:0] rom_b;
    logic [N_GATES-1:0] rom_y;
    logic [N_GATES-1:0] new_mask;
    logic               sample;
    logic               last;

    // The ROM is addressed with the vector about to be driven; its expected
    // Y is registered alongside A/B so one lookup serves both purposes.
    always_comb begin
        load_idx = (state == ST_IDLE) ? 3'd0 : idx + 3'd1;
        rom_func = (state == ST_IDLE) ? FUNC : func_q;
        new_mask = FAIL_MASK | (Y ^ exp_q);
        sample   = (cnt == CW'(SETTLE - 1));
        last     = (idx == 3'(NUM_VECTORS - 1));
    end

    quad_gate_vector_rom #(
        .N_GATES(N_GATES)
    ) u_rom (
        .idx  (load_idx),
        .func (rom_func),
        .a    (rom_a),
        .b    (rom_b),
        .y_exp(rom_y)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            func_q    <= '0;
            exp_q     <= '0;
            A         <= '0;
            B         <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_MASK <= '0;
            ERR       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        func_q    <= FUNC;
                        FAIL_MASK <= '0;
                        PASS      <= 1'b0;
                        BUSY      <= 1'b1;
                        cnt       <= '0;
                        idx       <= '0;
                        if (func_legal(FUNC)) begin
                            state <= ST_RUN;
                            ERR   <= 1'b0;
                            A     <= rom_a;
                            B     <= rom_b;
                            exp_q <= rom_y;
                        end else begin
                            state <= ST_FLAG;
                            ERR   <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (sample) begin
                        FAIL_MASK <= new_mask;
                        cnt       <= '0;
                        if (last) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                            A     <= '0;
                            B     <= '0;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (new_mask == '0) && !ERR;
                        end else begin
                            idx   <= idx + 3'd1;
                            A     <= rom_a;
                            B     <= rom_b;
                            exp_q <= rom_y;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_FLAG: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    PASS  <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_gate_bist.sv
// Scoreboard bench for quad_gate_bist driving a behavioural quad gate model
// with optional stuck-at-0 outputs.
module tb_quad_gate_bist;

    logic       CLK;
    logic       RST_n;
    logic       START;
    logic [2:0] FUNC;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Y;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [3:0] FAIL_MASK;
    logic       ERR;

    int          model;
    logic [3:0]  stuck0;
    logic [3:0]  y_raw;
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        int unsigned start_cyc;
        logic        pass;
        logic [3:0]  mask;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [3:0] va [6];
    logic [3:0] vb [6];

    quad_gate_bist #(
        .N_GATES(4),
        .SETTLE (2)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .START    (START),
        .FUNC     (FUNC),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .FAIL_MASK(FAIL_MASK),
        .ERR      (ERR)
    );

    always_comb begin
        case (model)
            0:       y_raw = A & B;
            4:       y_raw = A ^ B;
            default: y_raw = A | B;
        endcase
        Y = y_raw & ~stuck0;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per DONE pulse and tracks A/B per run.
    bit          busy_prev = 1'b0;
    int unsigned run_cyc = 0;
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got DONE=1 expected no DONE (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                check("pass", 32'(PASS), 32'(e.pass));
                check("fail_mask", 32'(FAIL_MASK), 32'(e.mask));
                check("err", 32'(ERR), 32'(e.err));
                check("done_busy_low", 32'(BUSY), 32'd0);
                check("done_ab_zero", 32'({A, B}), 32'd0);
            end
        end
        if (BUSY === 1'b1 && !busy_prev) begin
            run_cyc = 0;
            check("start_mask_clear", 32'(FAIL_MASK), 32'd0);
            check("start_pass_clear", 32'(PASS), 32'd0);
        end else if (BUSY === 1'b1) begin
            run_cyc++;
        end
        if (BUSY === 1'b1) begin
            if (ERR === 1'b1) begin
                check("flag_ab_zero", 32'({A, B}), 32'd0);
            end else if (run_cyc % 2 == 0 && run_cyc / 2 < 6) begin
                check("vec_a", 32'(A), 32'(va[run_cyc / 2]));
                check("vec_b", 32'(B), 32'(vb[run_cyc / 2]));
            end
        end
        busy_prev = (BUSY === 1'b1);
    end

    task automatic start_run(input logic [2:0] f, input logic ep, input logic [3:0] em,
                             input logic ee, input int unsigned lat, input bit push);
        exp_t x;
        FUNC  = f;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        x.start_cyc = cyc;
        x.pass = ep;
        x.mask = em;
        x.err  = ee;
        x.lat  = lat;
        if (push) sb.push_back(x);
    endtask

    task automatic wait_done();
        repeat (14) @(posedge CLK);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_A"}, 32'(A), 32'd0);
        check({tag, "_B"}, 32'(B), 32'd0);
        check({tag, "_BUSY"}, 32'(BUSY), 32'd0);
        check({tag, "_DONE"}, 32'(DONE), 32'd0);
        check({tag, "_PASS"}, 32'(PASS), 32'd0);
        check({tag, "_MASK"}, 32'(FAIL_MASK), 32'd0);
        check({tag, "_ERR"}, 32'(ERR), 32'd0);
    endtask

    initial begin
        va[0] = 4'b0000; vb[0] = 4'b0000;
        va[1] = 4'b0000; vb[1] = 4'b1111;
        va[2] = 4'b1111; vb[2] = 4'b0000;
        va[3] = 4'b1111; vb[3] = 4'b1111;
        va[4] = 4'b1010; vb[4] = 4'b0000;
        va[5] = 4'b0000; vb[5] = 4'b0101;

        n_cmp  = 0;
        n_bad  = 0;
        model  = 1;
        stuck0 = 4'b0000;
        RST_n  = 1'b0;
        START  = 1'b0;
        FUNC   = 3'b000;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST_n = 1'b1;
        @(posedge CLK);
        #1;

        // good OR part, OR expected
        start_run(3'b001, 1'b1, 4'b0000, 1'b0, 12, 1'b1);
        wait_done();

        // gate 2 output stuck at 0
        stuck0 = 4'b0100;
        start_run(3'b001, 1'b0, 4'b0100, 1'b0, 12, 1'b1);
        wait_done();
        stuck0 = 4'b0000;

        // AND expected from an OR part
        start_run(3'b000, 1'b0, 4'b1111, 1'b0, 12, 1'b1);
        wait_done();

        // illegal FUNC, then a legal run clears ERR
        start_run(3'b111, 1'b0, 4'b0000, 1'b1, 1, 1'b1);
        wait_done();
        start_run(3'b001, 1'b1, 4'b0000, 1'b0, 12, 1'b1);
        wait_done();

        // START re-pulsed mid-run with OR is ignored: AND run still fails everywhere
        start_run(3'b000, 1'b0, 4'b1111, 1'b0, 12, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        FUNC  = 3'b001;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        // now in the DONE cycle: this START must be accepted
        model = 4;
        start_run(3'b100, 1'b1, 4'b0000, 1'b0, 12, 1'b1);
        wait_done();
        model = 1;

        // reset at cycle 5 of a faulty run: immediate return to reset values, no DONE
        stuck0 = 4'b0100;
        start_run(3'b001, 1'b0, 4'b0000, 1'b0, 12, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK);
        #1;
        RST_n  = 1'b1;
        stuck0 = 4'b0000;
        repeat (14) @(posedge CLK);
        #1;
        start_run(3'b001, 1'b1, 4'b0000, 1'b0, 12, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
